timer_seq_ctrl: RTL

Controller that sequences the 16-bit Avalon interval timer slave (status@0, control@1, periodl@2, periodh@3) on behalf of software or a hardware requester.
- Accepts a period/mode command and drives the programming sequence: stop, load period, start.
- Services the timer irq by clearing status, then emits a one-cycle tick and counts timeouts.
- Sits between the requester and the timer's s1 port, as the timer's sole master.

---
 rtl/timer_seq_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: sole bus master for a 16-bit Avalon interval timer; programs it (stop, load, start) and services its irq.
// Latency: bus outputs registered from next state; the start write lands 4 cycles after command accept.
// Backpressure: cmd_ready only in IDLE, or in RUN with no irq/stop pending. Optional readback check: TIMER_SEQ_VERIFY_EN.
module timer_seq_ctrl #(
   parameter int          TICK_W    = 16,
   parameter logic [15:0] STOP_CTRL = 16'h0008
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [31:0]       cmd_period,
   input  logic              cmd_continuous,
   input  logic              cmd_irq_en,
   input  logic              stop_req,
   output logic [2:0]        tmr_address,
   output logic              tmr_chipselect,
   output logic              tmr_write_n,
   output logic [15:0]       tmr_writedata,
   input  logic [15:0]       tmr_readdata,
   input  logic              tmr_irq,
   output logic              running,
   output logic              tick,
   output logic [TICK_W-1:0] tick_count,
   output logic              verify_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_STOP, S_WR_PL, S_WR_PH, S_START, S_RUN, S_CLR, S_HALT,
      S_RD_PL, S_RD_PL_W, S_RD_PH, S_RD_PH_W
   } state_t;

   localparam logic [TICK_W-1:0] CNT_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [31:0]         period_q;
   logic                cont_q, ie_q;
   logic [2:0]          addr_q, addr_d;
   logic                cs_q, cs_d;
   logic                wn_q, wn_d;
   logic [15:0]         wd_q, wd_d;
   logic                running_q, tick_q;
   logic [TICK_W-1:0]   tick_count_q;
   logic                vfail_d;
   logic                cmd_accept;

   // Service and stop requests take precedence over a new command while running.
   assign cmd_ready  = (state_q == S_IDLE) ||
                       ((state_q == S_RUN) && !tmr_irq && !stop_req);
   assign cmd_accept = cmd_valid && cmd_ready;

   // Next-state selection; RUN priority is irq, then stop, then reprogram.
   always_comb begin
      state_d = state_q;
      vfail_d = 1'b0;
      case (state_q)
         S_IDLE:  if (cmd_accept) state_d = S_STOP;
         S_STOP:  state_d = S_WR_PL;
         S_WR_PL: state_d = S_WR_PH;
`ifdef TIMER_SEQ_VERIFY_EN
         S_WR_PH: state_d = S_RD_PL;
         S_RD_PL: state_d = S_RD_PL_W;
         S_RD_PL_W: begin
            if (tmr_readdata != period_q[15:0]) begin
               vfail_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_RD_PH;
            end
         end
         S_RD_PH: state_d = S_RD_PH_W;
         S_RD_PH_W: begin
            if (tmr_readdata != period_q[31:16]) begin
               vfail_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_START;
            end
         end
`else
         S_WR_PH: state_d = S_START;
`endif
         S_START: state_d = S_RUN;
         S_RUN: begin
            if (tmr_irq)         state_d = S_CLR;
            else if (stop_req)   state_d = S_HALT;
            else if (cmd_accept) state_d = S_STOP;
         end
         // A one-shot timer has finished once its timeout is serviced.
         S_CLR:   state_d = cont_q ? S_RUN : S_IDLE;
         S_HALT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bus cycle decode from the state being entered, so every access is registered.
   always_comb begin
      cs_d   = 1'b0;
      wn_d   = 1'b1;
      addr_d = 3'd0;
      wd_d   = 16'h0000;
      case (state_d)
         S_STOP:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = STOP_CTRL;       end
         S_WR_PL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_q[15:0];  end
         S_WR_PH: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_q[31:16]; end
         S_START: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1;
                        wd_d = {12'b0, 1'b0, 1'b1, cont_q, ie_q};                         end
         S_CLR:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wd_d = 16'h0000;        end
         S_HALT:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = STOP_CTRL;       end
`ifdef TIMER_SEQ_VERIFY_EN
         S_RD_PL: begin cs_d = 1'b1; addr_d = 3'd2; end
         S_RD_PH: begin cs_d = 1'b1; addr_d = 3'd3; end
`endif
         default: ;
      endcase
   end

   // State, latched command, registered bus and status outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         period_q     <= 32'h0;
         cont_q       <= 1'b0;
         ie_q         <= 1'b0;
         addr_q       <= 3'd0;
         cs_q         <= 1'b0;
         wn_q         <= 1'b1;
         wd_q         <= 16'h0000;
         running_q    <= 1'b0;
         tick_q       <= 1'b0;
         tick_count_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cs_q      <= cs_d;
         wn_q      <= wn_d;
         wd_q      <= wd_d;
         running_q <= (state_d == S_RUN);
         tick_q    <= (state_d == S_CLR);
         if (state_d == S_CLR) tick_count_q <= tick_count_q + CNT_ONE;
         if (cmd_accept) begin
            period_q <= cmd_period;
            cont_q   <= cmd_continuous;
            ie_q     <= cmd_irq_en;
         end
      end
   end

`ifdef TIMER_SEQ_VERIFY_EN
   logic verr_q;

   // Readback mismatch is sticky until reset.
   always_ff @(posedge clk) begin
      if (!reset_n)     verr_q <= 1'b0;
      else if (vfail_d) verr_q <= 1'b1;
   end

   assign verify_err = verr_q;
`else
   logic unused_rd;
   assign unused_rd  = ^{tmr_readdata, vfail_d};
   assign verify_err = 1'b0;
`endif

   assign tmr_address    = addr_q;
   assign tmr_chipselect = cs_q;
   assign tmr_write_n    = wn_q;
   assign tmr_writedata  = wd_q;
   assign running        = running_q;
   assign tick           = tick_q;
   assign tick_count     = tick_count_q;

endmodule
